serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller: sequences a single 1-bit full-adder cell, built from two half adders, across WIDTH-bit operands, one bit per clock, LSB first. It is the shared-datapath alternative to a WIDTH-bit ripple adder in area-constrained arithmetic paths. A start/busy/done handshake lets an upstream controller issue one addition at a time.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; present only with SERIAL_ADD_CIN_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- s  output  WIDTH  sum; registered, held until the next result.
- cout  output  1  final carry; registered, held until the next result.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: WIDTH bit steps.
  - DONE: single cycle, done=1.
- IDLE, start=1: capture a and b into shift registers. Load the carry register with 0, or with cin when SERIAL_ADD_CIN_EN is defined. Clear the bit counter. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - The cell adds opA[0], opB[0] and the carry.
  - The sum bit shifts into the MSB of the sum shift register.
  - opA and opB shift right by one; the carry register takes the cell carry; the counter increments.
- RUN, counter == WIDTH-1: after that step, load s from the sum shift register and cout from the cell carry, then go to DONE.
- DONE: done=1, then go to IDLE unconditionally.
- start in RUN or DONE: ignored, not queued.
- a and b may change freely after the accepting edge without affecting the result.
- Arithmetic: {cout, s} = a + b (+ cin), modulo 2^(WIDTH+1); unsigned.
- Counter width: $clog2(WIDTH).

## Timing
- Reset values: state IDLE, busy=0, done=0, s=0, cout=0; internal shift, carry and counter registers are 0.
- start high in cycle T (IDLE) → busy=1 in cycles T+1 … T+WIDTH.
- done=1 and s/cout valid from cycle T+WIDTH+1.
- Start-to-done latency: WIDTH+1 cycles.
- Earliest next accept: start in cycle T+WIDTH+2 (IDLE).
- Throughput: one addition per WIDTH+2 cycles.
- busy and done are never high together.
- s and cout change only on the edge entering DONE, or on reset.
- rst=1 mid-RUN or in DONE: next edge returns to IDLE with all reset values; the partial result is discarded and done is not asserted.
- rst and start both high: rst wins.

## Configuration
- SERIAL_ADD_CIN_EN defined:
  - The cin port exists and is sampled with a and b on the accepting edge.
  - Result = a + b + cin.
- SERIAL_ADD_CIN_EN undefined:
  - No cin port; initial carry is 0.
  - Result = a + b.

## Structure
- serial_add_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}, 2 bits.
  - Localparam encodings for the states.
- Sub-module fa_cell (a, b, cin, s, cout):
  - Purely combinational; two half-adder stages plus an OR for carry-out.
  - Instantiated once; it is the only adder in the block.
- Controller, shift registers, counter and output registers are all in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- Reset, then idle 5 cycles → s=0x00, cout=0, busy=0, done=0 throughout.
- a=0x0F, b=0x01, start pulsed in cycle T → busy in T+1…T+8; done pulse in T+9 with s=0x10, cout=0.
- a=0xFF, b=0x01 → s=0x00, cout=1. Then a=0xA5, b=0x5A → s=0xFF, cout=0. Both issued back-to-back at the earliest accept.
- start held high through a whole operation with a/b changing every cycle → only the first request is used (0x3C+0x42 → s=0x7E); exactly one done per accept.
- rst asserted in the 4th RUN cycle → IDLE next cycle; done never pulses; s/cout=0. A fresh 0x80+0x80 afterwards → s=0x00, cout=1.
- With SERIAL_ADD_CIN_EN: a=0xFF, b=0x00, cin=1 → s=0x00, cout=1; with cin=0 → s=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: state encodings and the state enum.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages; the only adder in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    assign p    = a ^ b;
    assign g1   = a & b;
    assign s    = p ^ cin;
    assign g2   = p & cin;
    assign cout = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_cell stepped LSB-first over WIDTH bits with start/busy/done.
// Define SERIAL_ADD_CIN_EN to add the cin port and seed the carry from it.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               cell_s;
    logic               cell_c;
    logic               last_step;
    logic               carry_init;

`ifdef SERIAL_ADD_CIN_EN
    assign carry_init = cin;
`else
    assign carry_init = 1'b0;
`endif

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    fa_cell u_fa_cell (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The final step writes s directly from the shifted value so the result is ready on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= carry_init;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= cell_c;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        s    <= {cell_s, sum_sr[WIDTH-1:1]};
                        cout <= cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); cin cases need SERIAL_ADD_CIN_EN.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_CIN_EN
        .cin   (cin),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle, verify busy window, done pulse and result; returns in the done cycle.
    task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic [7:0] es, input logic ec);
        int unsigned busy_ok;
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        busy_ok = 1;
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            tick();
            start = 1'b0;
            a     = 8'h00;
            b     = 8'h00;
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
        end
        check({tag, " busy window"}, busy_ok, 1);
        tick();
        check({tag, " done"}, {busy, done}, 2'b01);
        check({tag, " s"}, s, es);
        check({tag, " cout"}, cout, ec);
    endtask

    initial begin
        int unsigned idle_ok;
        int unsigned n_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        idle_ok = 1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || cout !== 1'b0) idle_ok = 0;
        end
        check("reset idle", idle_ok, 1);

        run_add("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        tick();
        check("held after done s", s, 8'h10);
        check("back to idle", {busy, done}, 2'b00);

        // Back-to-back at the earliest accept.
        run_add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        run_add("A5+5A", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
        tick();

        // start held high with operands churning; only the first request counts.
        a      = 8'h3C;
        b      = 8'h42;
        start  = 1'b1;
        n_done = 0;
        for (int unsigned i = 1; i <= WIDTH + 1; i++) begin
            tick();
            a = 8'($urandom);
            b = 8'($urandom);
            if (done === 1'b1) n_done++;
            if (i == WIDTH + 1) begin
                check("held start s", s, 8'h7E);
                check("held start cout", cout, 1'b0);
                start = 1'b0;
            end
        end
        check("held start one done", n_done, 1);
        tick();
        check("held start no requeue", {busy, done}, 2'b00);

        // Reset in the 4th RUN cycle discards the operation.
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("4th run cycle busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset mid-run state", {busy, done}, 2'b00);
        check("reset mid-run s", s, 8'h00);
        check("reset mid-run cout", cout, 1'b0);
        n_done = 0;
        for (int unsigned i = 0; i < WIDTH + 2; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        check("no done after reset", n_done, 0);

        run_add("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        tick();

`ifdef SERIAL_ADD_CIN_EN
        run_add("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        tick();
        run_add("FF+00+0", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
